// File: rtl/serial_subtractor_dp.sv
// Digit-serial A - B - borrow_in, DIGIT bits per cycle, LSB digit first.
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_dp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor_dp: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             br_reg;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   sub;
  logic [WIDTH-1:0] diff_nxt;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign last = (idx == LAST);

  // One digit of the borrow chain, widened by a bit to expose the borrow.
  always_comb begin
    a_dig    = a_reg[idx*DIGIT +: DIGIT];
    b_dig    = b_reg[idx*DIGIT +: DIGIT];
    sub      = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, br_reg};
    diff_nxt = diff;
    diff_nxt[idx*DIGIT +: DIGIT] = sub[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      br_reg     <= 1'b0;
      idx        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            br_reg <= borrow_in;
            idx    <= '0;
          end
        end
        S_RUN: begin
          diff   <= diff_nxt;
          br_reg <= sub[DIGIT];
          if (last) begin
            borrow_out <= sub[DIGIT];
            zero       <= (diff_nxt == '0);
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                   (diff_nxt[WIDTH-1] != a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_dp.sv
// Self-checking bench for serial_subtractor_dp (WIDTH=16, DIGIT=4).
// Table vectors, handshake corner cases and random ops vs arithmetic model.
module tb_serial_subtractor_dp;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow_out, zero;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor_dp #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .borrow_in(borrow_in),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out),
    .zero(zero)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bin);
    vec_t r;
    int unsigned full;
    full  = (int'(x) + 32'h10000 - int'(y) - int'(bin)) & 32'h1FFFF;
    r.a   = x;
    r.b   = y;
    r.bin = bin;
    r.d   = full[W-1:0];
    r.bo  = (int'(x) < int'(y) + int'(bin));
    r.z   = (r.d == 0);
    return r;
  endfunction

  // Runs one op; disturb=1 re-drives start/operands during RUN and DONE.
  task automatic run_op(input vec_t v, input bit disturb);
    bit busy_ok;
    int dc0;
    @(negedge clk);
    a = v.a;
    b = v.b;
    borrow_in = v.bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    dc0 = done_cnt;
    start = disturb;
    a = disturb ? 16'hFFFF : W'($urandom);
    b = W'($urandom);
    borrow_in = ~v.bin;
    busy_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("busy_run_cycles", 32'(busy_ok), 32'd1);
    check("done_pulse", {30'd0, done, busy}, 32'h2);
    check("diff", 32'(diff), 32'(v.d));
    check("borrow_out", 32'(borrow_out), 32'(v.bo));
    check("zero", 32'(zero), 32'(v.z));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("ovf", 32'(ovf),
          32'((v.a[W-1] != v.b[W-1]) && (v.d[W-1] != v.a[W-1])));
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    check("after_done", {29'd0, done, busy, zero}, {31'd0, v.z});
    check("diff_held", 32'(diff), 32'(v.d));
    check("one_done", 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int dc0;
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[7] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    borrow_in = 1'b0;
    #12;
    check("reset_state", {27'd0, busy, done, borrow_out, zero, |diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b0);

    run_op(tbl[0], 1'b1);

    // Abort in the second RUN cycle, then a clean op.
    @(negedge clk);
    a = 16'h0F0F;
    b = 16'h0101;
    borrow_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_outs", {27'd0, busy, done, borrow_out, zero, |diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    check("abort_idle", {30'd0, busy, |diff}, 32'd0);
    run_op(model(16'h0F0F, 16'h0101, 1'b0), 1'b0);

    for (int i = 0; i < 20; i++) begin
      v = model(W'($urandom), W'($urandom), 1'($urandom));
      run_op(v, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
